countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Loadable down-counter timer with prescaler, one-shot/periodic modes, terminal-count pulse,
//  and a sticky underflow flag. It complements the up-counting counter block in the keyboard FPGA.
//  It supplies the fixed-interval ticks for the matrix scan, debounce windows and repeat delays.
// PARAMETERS
//  BIT_WIDTH   16  width of count, load_value and the reload register
//  PRESCALE    1   enabled clk cycles per decrement; legal range >=1 (1 = no prescale)
//  PS_WIDTH    clog2(PRESCALE)+1, derived localparam; width of the prescale counter
// PORTS
//  clk         in   1          system clock; all state changes on posedge
//  rst         in   1          asynchronous, active-high reset
//  en          in   1          global enable; 0 freezes prescaler and count, state held
//  load        in   1          sample load_value into count and reload register
//  load_value  in   BIT_WIDTH  value loaded on load
//  start       in   1          IDLE/DONE -> RUN (resume from current count)
//  stop        in   1          RUN -> IDLE (pause; count and prescaler held)
//  periodic    in   1          1: auto-reload at terminal count; 0: one-shot
//  clr_flag    in   1          clear sticky underflow
//  count       out  BIT_WIDTH  current count value
//  running     out  1          1 while state == RUN
//  tc_pulse    out  1          single-cycle pulse at terminal count
//  underflow   out  1          sticky; set on every terminal count, cleared by clr_flag
// BEHAVIOUR
//  Reset (async):
//   - count=0, reload=0, prescale counter=0, state=IDLE
//   - running=0, tc_pulse=0, underflow=0
//  States: IDLE, RUN, DONE. All outputs are registered. running is 1 exactly in RUN.
//  Priority within one cycle: load > stop > start > tick.
//   - load and stop/start act independently: load updates count, reload and prescaler;
//     stop/start update the state.
//  load (any state):
//   - count<=load_value, reload<=load_value, prescale counter<=0; suppresses that cycle's tick
//   - DONE -> IDLE
//   - load_value==0 forces IDLE
//  start:
//   - IDLE or DONE with count!=0 -> RUN
//   - ignored when count==0 (after load: the new count)
//   - ignored in RUN
//  stop: RUN -> IDLE; no effect elsewhere. stop and start in the same cycle: stop wins.
//  Prescaler: in RUN with en=1, increments each cycle; at PRESCALE-1 it wraps to 0 and issues a tick.
//  Tick with count>1: count<=count-1.
//  Tick with count==1 (terminal), all on the same edge:
//   - tc_pulse<=1 for exactly one cycle; underflow<=1
//   - periodic=1: count<=reload, stay in RUN
//   - periodic=0: count<=0, state DONE
//  Interval: with load N and PRESCALE P, the first tc_pulse comes N*P enabled cycles after the start edge.
//   - periodic mode repeats every N*P enabled cycles; no dead cycle at reload.
//  underflow: the set has priority over clr_flag in the same cycle.
//  en=0 in RUN: no prescaler advance and no tick; load, stop, start and clr_flag still act.
//  Arithmetic is unsigned BIT_WIDTH. count never wraps below 0; terminal detection is at 1.
//  Reset mid-run: immediate return to the reset values; no tc_pulse is emitted.
// STRUCTURE
//  Shared package keyboard_fpga_pkg: state encodings TMR_IDLE/TMR_RUN/TMR_DONE, and a clog2 function.
//  Sub-module tick_prescaler (en, clr, PRESCALE -> tick) holds the prescale counter.
//  Top level holds the FSM, the count/reload registers and the flag logic.
// TESTING
//  1 Reset: assert rst mid-RUN with count=5 -> all outputs 0 the same cycle; state IDLE.
//  2 One-shot, P=1: load 3, start -> count 3,2,1,0; tc_pulse on the 3rd cycle after start;
//    state DONE, running=0, underflow=1.
//  3 Periodic, P=4: load 2, start -> tc_pulse every 8 cycles, count reloads to 2;
//    en held low 5 cycles stretches that interval to 13.
//  4 Pause/resume: stop at count=4 -> count holds 4 for 10 cycles; start -> decrements resume;
//    stop+start same cycle -> IDLE.
//  5 Edges: start with count=0 ignored; load 0 in RUN -> IDLE;
//    clr_flag coincident with terminal count -> underflow stays 1.
//  6 Load during RUN at count=1 on a tick cycle -> count=load_value, no tc_pulse, prescaler cleared.

Source files
------------

// File: rtl/keyboard_fpga_pkg.sv
// Shared keyboard FPGA definitions: timer state encodings and a constant clog2 helper.
package keyboard_fpga_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescale counter: emits one tick every PRESCALE enabled cycles; clr restarts the interval.
module tick_prescaler
  import keyboard_fpga_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS_WIDTH = clog2(PRESCALE) + 1;
  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] ps_count;

  // clr suppresses the tick of the cycle it arrives in
  assign tick = en && !clr && (ps_count == PS_LAST);

  // prescale counter: cleared by clr, advances only while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_count <= {PS_WIDTH{1'b0}};
    end else if (clr) begin
      ps_count <= {PS_WIDTH{1'b0}};
    end else if (en) begin
      if (ps_count == PS_LAST) begin
        ps_count <= {PS_WIDTH{1'b0}};
      end else begin
        ps_count <= ps_count + PS_WIDTH'(1);
      end
    end else begin
      ps_count <= ps_count;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with prescaler, one-shot/periodic modes, tc pulse and sticky underflow.
module countdown_timer
  import keyboard_fpga_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] load_value,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 periodic,
  input  logic                 clr_flag,
  output logic [BIT_WIDTH-1:0] count,
  output logic                 running,
  output logic                 tc_pulse,
  output logic                 underflow
);

  tmr_state_t           state;
  tmr_state_t           state_next;
  logic [BIT_WIDTH-1:0] reload;
  logic [BIT_WIDTH-1:0] count_next;
  logic [BIT_WIDTH-1:0] count_eff;
  logic                 ps_en;
  logic                 tick;
  logic                 terminal;

  // stop pauses the prescaler in the same cycle it leaves RUN
  assign ps_en    = en && (state == TMR_RUN) && !stop;
  assign terminal = tick && (count == BIT_WIDTH'(1));

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (ps_en),
    .clr (load),
    .tick(tick)
  );

  // next count and next state; start sees the freshly loaded count
  always_comb begin
    count_next = count;
    state_next = state;
    count_eff  = load ? load_value : count;

    if (load) begin
      count_next = load_value;
    end else if (terminal) begin
      count_next = periodic ? reload : {BIT_WIDTH{1'b0}};
    end else if (tick && (count != {BIT_WIDTH{1'b0}})) begin
      count_next = count - BIT_WIDTH'(1);
    end else begin
      count_next = count;
    end

    case (state)
      TMR_IDLE: begin
        if (start && !stop && (count_eff != {BIT_WIDTH{1'b0}})) begin
          state_next = TMR_RUN;
        end else begin
          state_next = TMR_IDLE;
        end
      end
      TMR_RUN: begin
        if (stop) begin
          state_next = TMR_IDLE;
        end else if (terminal && !periodic) begin
          state_next = TMR_DONE;
        end else begin
          state_next = TMR_RUN;
        end
      end
      TMR_DONE: begin
        if (start && !stop && (count_eff != {BIT_WIDTH{1'b0}})) begin
          state_next = TMR_RUN;
        end else if (load) begin
          state_next = TMR_IDLE;
        end else begin
          state_next = TMR_DONE;
        end
      end
      default: begin
        state_next = TMR_IDLE;
      end
    endcase

    if (load && (load_value == {BIT_WIDTH{1'b0}})) begin
      state_next = TMR_IDLE;
    end else begin
      state_next = state_next;
    end
  end

  // state, count, reload and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TMR_IDLE;
      count     <= {BIT_WIDTH{1'b0}};
      reload    <= {BIT_WIDTH{1'b0}};
      running   <= 1'b0;
      tc_pulse  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      running  <= (state_next == TMR_RUN);
      tc_pulse <= terminal;
      if (load) begin
        reload <= load_value;
      end
      if (terminal) begin
        underflow <= 1'b1;
      end else if (clr_flag) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
